// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the SAP control sequencer: state encoding, step width,
// fetch length and the execute-step normalisation helper.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F_ADDR = 3'd1,
    S_F_MEM  = 3'd2,
    S_F_IR   = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  localparam int STEP_W       = 2;
  localparam int FETCH_CYCLES = 3;

  // A decoder reporting zero execute steps still gets one.
  function automatic logic [STEP_W-1:0] eff_steps(input logic [STEP_W-1:0] req);
    return (req == '0) ? STEP_W'(1) : req;
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// SAP ring-counter sequencer: 3-cycle fetch, then 1..3 execute steps, with run/halt
// and a retired-instruction counter. Optional macro SINGLE_STEP_EN adds step_req.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [STEP_W-1:0] steps_required,
`ifdef SINGLE_STEP_EN
  input  logic              step_req,
`endif
  output logic              fetch_complete,
  output logic [STEP_W-1:0] step,
  output logic              mar_load_pc,
  output logic              ram_read,
  output logic              ir_load,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count,
  output state_t            fsm_state
);

  // Handshake: none. Strobes are pure functions of state; run and step_req are
  // sampled on the rising edge and only matter in IDLE and on the last EXEC step.

  state_t            state, state_nxt;
  logic [STEP_W-1:0] step_q, step_nxt;
  logic [STEP_W-1:0] steps_lat, steps_lat_nxt;
  logic [STEP_W-1:0] steps_cur;
  logic              retire;
  logic              start;
  logic              keep_going;

`ifdef SINGLE_STEP_EN
  logic req_q;
  logic single_q;
  logic req_rise;

  assign req_rise = step_req & ~req_q;

  // single_q marks an instruction launched by step_req alone; it forces IDLE afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      single_q <= 1'b0;
    end else begin
      req_q <= step_req;
      if (state == S_IDLE) single_q <= ~run & req_rise;
    end
  end

  assign start      = run | req_rise;
  assign keep_going = run & ~single_q;
`else
  assign start      = run;
  assign keep_going = run;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      step_q      <= '0;
      steps_lat   <= STEP_W'(1);
      instr_count <= '0;
    end else begin
      state     <= state_nxt;
      step_q    <= step_nxt;
      steps_lat <= steps_lat_nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Step 0 uses the live decoder value; later steps use the latched copy.
  assign steps_cur = (step_q == '0) ? eff_steps(steps_required) : steps_lat;

  always_comb begin
    state_nxt     = state;
    step_nxt      = step_q;
    steps_lat_nxt = steps_lat;
    retire        = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_F_ADDR;
      S_F_ADDR: state_nxt = S_F_MEM;
      S_F_MEM:  state_nxt = S_F_IR;
      S_F_IR: begin
        state_nxt = S_EXEC;
        step_nxt  = '0;
      end
      S_EXEC: begin
        if (step_q == '0) steps_lat_nxt = steps_cur;
        if (step_q == steps_cur - STEP_W'(1)) begin
          retire    = 1'b1;
          step_nxt  = '0;
          state_nxt = keep_going ? S_F_ADDR : S_IDLE;
        end else begin
          step_nxt = step_q + STEP_W'(1);
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign fetch_complete = (state == S_EXEC);
  assign step           = (state == S_EXEC) ? step_q : '0;
  assign mar_load_pc    = (state == S_F_ADDR);
  assign ram_read       = (state == S_F_MEM);
  assign ir_load        = (state == S_F_IR);
  assign halted         = (state == S_IDLE);
  assign fsm_state      = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a cycle-position reference model pushes expected
// outputs per clock; a negedge monitor pops and compares. Honours SINGLE_STEP_EN.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam int CNT_W = 8;
  localparam int VW    = 7 + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic [1:0]       steps_required = 2'd1;
  logic             step_req = 1'b0;
  logic             fetch_complete, mar_load_pc, ram_read, ir_load, halted;
  logic [1:0]       step;
  logic [CNT_W-1:0] instr_count;
  state_t           fsm_state;

  int errors = 0;
  int checks = 0;

  logic [VW-1:0] exp_q[$];
  localparam logic [VW-1:0] RESET_VEC = {1'b1, 6'b0, {CNT_W{1'b0}}};

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .steps_required(steps_required),
`ifdef SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .fetch_complete(fetch_complete), .step(step), .mar_load_pc(mar_load_pc),
    .ram_read(ram_read), .ir_load(ir_load), .halted(halted),
    .instr_count(instr_count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {halted, fetch_complete, mar_load_pc, ram_read, ir_load, step, instr_count};
  endfunction

  // Reference model: busy flag plus position k inside the instruction
  // (0..2 fetch, 3.. execute), instruction length n, retired count.
  bit               busy, single, prev_req, rise;
  int               k, n, e;
  logic [CNT_W-1:0] cnt;

  function automatic logic [VW-1:0] model_vec();
    logic [1:0] s;
    s = (busy && k >= 3) ? 2'(k - 3) : 2'd0;
    return {!busy, busy && k >= 3, busy && k == 0, busy && k == 1, busy && k == 2, s, cnt};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; single = 0; prev_req = 0; k = 0; n = 1; cnt = '0;
      exp_q.delete();
    end else begin
`ifdef SINGLE_STEP_EN
      rise = step_req && !prev_req;
`else
      rise = 0;
`endif
      prev_req = step_req;
      if (!busy) begin
        if (run || rise) begin
          busy = 1; k = 0; single = !run;
        end
      end else if (k < 3) begin
        k++;
      end else begin
        e = k - 3;
        if (e == 0) n = (steps_required == 0) ? 1 : int'(steps_required);
        if (e == n - 1) begin
          cnt = cnt + 1'b1;
          if (run && !single) k = 0;
          else busy = 0;
        end else begin
          k++;
        end
      end
      exp_q.push_back(model_vec());
    end
  end

  // Monitor: reset state while rst_n is low, otherwise pop the model's expectation.
  always @(negedge clk) begin
    logic [VW-1:0] exp_v;
    checks++;
    if (!rst_n) begin
      if (dut_vec() !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_state: got %h want %h", dut_vec(), RESET_VEC);
      end
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      exp_v = exp_q.pop_front();
      if (dut_vec() !== exp_v) begin
        errors++;
        $display("FAIL outputs at %0t: got hfcmri_st_cnt=%b want %b", $time, dut_vec(), exp_v);
      end
    end
  end

  task automatic cyc(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Waits at negedges for a DUT condition; sel 0: EXEC step 1, sel 1: ram_read.
  task automatic wait_for(input int sel, input string name);
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!((sel == 0) ? (fetch_complete && step == 2'd1) : ram_read) && budget < 40);
    checks++;
    if (budget >= 40) begin
      errors++;
      $display("FAIL wait_%s: condition not seen within 40 cycles", name);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(10);                                   // idle with run=0
    run = 1'b1; steps_required = 2'd2;
    cyc(15);                                   // steady 5-cycle pattern
    steps_required = 2'd3; cyc(12);
    steps_required = 2'd1; cyc(8);
    steps_required = 2'd0; cyc(8);
    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 9) != 0);
      steps_required = 2'($urandom_range(0, 3));
      cyc(1);
    end
    run = 1'b1;
    wait_for(1, "f_mem");
    #1 run = 1'b0;
    cyc(12);                                   // finishes, then halts
    run = 1'b1;
    for (int i = 0; i < 1700; i++) begin       // enough instructions to wrap the counter
      steps_required = 2'($urandom_range(0, 3));
      cyc(1);
    end
    steps_required = 2'd3;
    wait_for(0, "exec_step1");
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", dut_vec(), RESET_VEC);
    end
    #1 rst_n = 1'b1;
    cyc(20);
`ifdef SINGLE_STEP_EN
    run = 1'b0; cyc(8);
    step_req = 1'b1; cyc(1); step_req = 1'b0; cyc(10);      // one pulse
    step_req = 1'b1; cyc(15); step_req = 1'b0; cyc(3);      // held high
    step_req = 1'b1; cyc(1); step_req = 1'b0; cyc(3);       // pulse, then another mid-EXEC
    step_req = 1'b1; cyc(1); step_req = 1'b0; cyc(8);
    for (int i = 0; i < 300; i++) begin
      step_req = ($urandom_range(0, 3) == 0);
      run = ($urandom_range(0, 7) == 0);
      steps_required = 2'($urandom_range(0, 3));
      cyc(1);
    end
    step_req = 1'b0; run = 1'b0;
`endif
    run = 1'b0; cyc(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
